// File: rtl/midi_note_decoder.sv
// midi_note_decoder: turns the MIDI byte stream into a monophonic note state.
// Last-note priority. A Note Off only releases the note that is currently sounding.
// Optional feature: define MIDI_RUNNING_STATUS_EN to enable running status.
module midi_note_decoder #(
    parameter int unsigned MIDI_CHANNEL = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [6:0]  note,
    output logic [6:0]  velocity,
    output logic        gate,
    output logic [31:0] freq_out,
    output logic        note_strobe
);

    localparam int unsigned FREQ_W = 32;

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;

    state_t            state, state_nxt;
    logic [7:0]        status, status_nxt;
    logic [6:0]        d1, d1_nxt;
    logic [6:0]        note_nxt, velocity_nxt;
    logic              gate_nxt, strobe_nxt;
    logic [FREQ_W-1:0] freq_nxt;
    logic              take_d1, complete;
    logic [6:0]        msg_d1, msg_d2;

    // Note number to integer Hz: the octave-9 value for the semitone, shifted down by octave
    function automatic logic [FREQ_W-1:0] note_freq(input logic [6:0] n);
        logic [6:0]  k;
        logic [6:0]  s;
        logic [13:0] t;
        k = n / 7'd12;
        s = n - 7'(k * 7'd12);
        case (s)
            7'd0:    t = 14'd8372;
            7'd1:    t = 14'd8870;
            7'd2:    t = 14'd9397;
            7'd3:    t = 14'd9956;
            7'd4:    t = 14'd10548;
            7'd5:    t = 14'd11175;
            7'd6:    t = 14'd11840;
            7'd7:    t = 14'd12544;
            7'd8:    t = 14'd13290;
            7'd9:    t = 14'd14080;
            7'd10:   t = 14'd14917;
            default: t = 14'd15804;
        endcase
        return FREQ_W'(t >> (4'd10 - 4'(k)));
    endfunction

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            status      <= 8'h00;
            d1          <= 7'd0;
            note        <= 7'd0;
            velocity    <= 7'd0;
            gate        <= 1'b0;
            freq_out    <= '0;
            note_strobe <= 1'b0;
        end else begin
            state       <= state_nxt;
            status      <= status_nxt;
            d1          <= d1_nxt;
            note        <= note_nxt;
            velocity    <= velocity_nxt;
            gate        <= gate_nxt;
            freq_out    <= freq_nxt;
            note_strobe <= strobe_nxt;
        end
    end

    // Byte classification, message assembly and note update
    always_comb begin
        state_nxt    = state;
        status_nxt   = status;
        d1_nxt       = d1;
        note_nxt     = note;
        velocity_nxt = velocity;
        gate_nxt     = gate;
        freq_nxt     = freq_out;
        strobe_nxt   = 1'b0;
        take_d1      = 1'b0;
        complete     = 1'b0;
        msg_d1       = d1;
        msg_d2       = 7'd0;

        if (rx_valid && !(&rx_data[7:3])) begin
            if (rx_data[7:4] == 4'hF) begin
                status_nxt = 8'h00;
                state_nxt  = IDLE;
            end else if (rx_data[7]) begin
                status_nxt = rx_data;
                state_nxt  = WAIT_D1;
            end else begin
                case (state)
                    WAIT_D1: take_d1 = 1'b1;
                    WAIT_D2: begin
                        complete = 1'b1;
                        msg_d1   = d1;
                        msg_d2   = rx_data[6:0];
                    end
                    default: begin
`ifdef MIDI_RUNNING_STATUS_EN
                        if (status != 8'h00) take_d1 = 1'b1;
`endif
                    end
                endcase
            end
        end

        // First data byte: program/pressure messages end here
        if (take_d1) begin
            d1_nxt = rx_data[6:0];
            if (status[7:4] == 4'hC || status[7:4] == 4'hD) begin
                complete = 1'b1;
                msg_d1   = rx_data[6:0];
            end else begin
                state_nxt = WAIT_D2;
            end
        end

        // Act on completed note messages for our channel
        if (complete) begin
            if (status[7:5] == 3'b100 && status[3:0] == 4'(MIDI_CHANNEL)) begin
                if (status[4] && msg_d2 != 7'd0) begin
                    note_nxt     = msg_d1;
                    velocity_nxt = msg_d2;
                    gate_nxt     = 1'b1;
                    freq_nxt     = note_freq(msg_d1);
                    strobe_nxt   = 1'b1;
                end else if (gate && msg_d1 == note) begin
                    gate_nxt   = 1'b0;
                    strobe_nxt = 1'b1;
                end
            end
`ifdef MIDI_RUNNING_STATUS_EN
            state_nxt = WAIT_D1;
`else
            state_nxt  = IDLE;
            status_nxt = 8'h00;
`endif
        end
    end

endmodule

// File: tb/tb_midi_note_decoder.sv
// tb_midi_note_decoder: byte-stream vectors with hand-computed note state.
module tb_midi_note_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [6:0]  note;
    logic [6:0]  velocity;
    logic        gate;
    logic [31:0] freq_out;
    logic        note_strobe;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  b;
        logic [6:0]  n;
        logic [6:0]  v;
        logic        g;
        logic [31:0] f;
        logic        s;
    } vec_t;

    vec_t tbl[$];

    midi_note_decoder #(.MIDI_CHANNEL(0)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .note(note), .velocity(velocity), .gate(gate), .freq_out(freq_out),
        .note_strobe(note_strobe)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [7:0] b, input logic [6:0] n, input logic [6:0] v,
                       input logic g, input logic [31:0] f, input logic s);
        vec_t e;
        e.b = b; e.n = n; e.v = v; e.g = g; e.f = f; e.s = s;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [6:0] n, input logic [6:0] v,
                         input logic g, input logic [31:0] f, input logic s);
        checks++;
        if (note !== n || velocity !== v || gate !== g || freq_out !== f || note_strobe !== s) begin
            failures++;
            $display("FAIL %s: got note=%0d vel=%0d gate=%0b freq=%0d strobe=%0b, want note=%0d vel=%0d gate=%0b freq=%0d strobe=%0b",
                     name, note, velocity, gate, freq_out, note_strobe, n, v, g, f, s);
        end
    endtask

    // One byte per cycle, sampled 1 time unit after the edge
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;

        // A4 note on
        add(8'h90, 0, 0, 0, 0, 0);
        add(8'h45, 0, 0, 0, 0, 0);
        add(8'h64, 69, 100, 1, 440, 1);
        // C4 takes over
        add(8'h90, 69, 100, 1, 440, 0);
        add(8'h3C, 69, 100, 1, 440, 0);
        add(8'h50, 60, 80, 1, 261, 1);
        // Note Off for 69 is ignored
        add(8'h80, 60, 80, 1, 261, 0);
        add(8'h45, 60, 80, 1, 261, 0);
        add(8'h00, 60, 80, 1, 261, 0);
        // 9x velocity 0 releases 60
        add(8'h90, 60, 80, 1, 261, 0);
        add(8'h3C, 60, 80, 1, 261, 0);
        add(8'h00, 60, 80, 0, 261, 1);
        // Other channel, then program change
        add(8'h91, 60, 80, 0, 261, 0);
        add(8'h45, 60, 80, 0, 261, 0);
        add(8'h64, 60, 80, 0, 261, 0);
        add(8'hC0, 60, 80, 0, 261, 0);
        add(8'h05, 60, 80, 0, 261, 0);
        add(8'h90, 60, 80, 0, 261, 0);
        add(8'h30, 60, 80, 0, 261, 0);
        add(8'h7F, 48, 127, 1, 130, 1);
        // Real-time byte mid-message
        add(8'h90, 48, 127, 1, 130, 0);
        add(8'h40, 48, 127, 1, 130, 0);
        add(8'hF8, 48, 127, 1, 130, 0);
        add(8'h7F, 64, 127, 1, 329, 1);
        // Running status candidate
        add(8'h90, 64, 127, 1, 329, 0);
        add(8'h45, 64, 127, 1, 329, 0);
        add(8'h64, 69, 100, 1, 440, 1);
        add(8'h48, 69, 100, 1, 440, 0);
`ifdef MIDI_RUNNING_STATUS_EN
        add(8'h64, 72, 100, 1, 523, 1);
        add(8'h90, 72, 100, 1, 523, 0);
        add(8'h48, 72, 100, 1, 523, 0);
        add(8'h50, 72, 80, 1, 523, 1);
        add(8'h80, 72, 80, 1, 523, 0);
        add(8'h48, 72, 80, 1, 523, 0);
        add(8'h40, 72, 80, 0, 523, 1);
        add(8'h90, 72, 80, 0, 523, 0);
        add(8'h45, 72, 80, 0, 523, 0);
        add(8'hF0, 72, 80, 0, 523, 0);
        add(8'h64, 72, 80, 0, 523, 0);
`else
        add(8'h64, 69, 100, 1, 440, 0);
        // Retrigger of the same note strobes
        add(8'h90, 69, 100, 1, 440, 0);
        add(8'h45, 69, 100, 1, 440, 0);
        add(8'h50, 69, 80, 1, 440, 1);
        add(8'h80, 69, 80, 1, 440, 0);
        add(8'h45, 69, 80, 1, 440, 0);
        add(8'h40, 69, 80, 0, 440, 1);
        // System exclusive aborts the message
        add(8'h90, 69, 80, 0, 440, 0);
        add(8'h45, 69, 80, 0, 440, 0);
        add(8'hF0, 69, 80, 0, 440, 0);
        add(8'h64, 69, 80, 0, 440, 0);
`endif
        // Frequency boundaries, lowest and highest note
        add(8'h90, tbl[$].n, tbl[$].v, tbl[$].g, tbl[$].f, 0);
        add(8'h00, tbl[$].n, tbl[$].v, tbl[$].g, tbl[$].f, 0);
        add(8'h01, 0, 1, 1, 8, 1);
        add(8'h90, 0, 1, 1, 8, 0);
        add(8'h7F, 0, 1, 1, 8, 0);
        add(8'h7F, 127, 127, 1, 12544, 1);
        // New status discards partial message
        add(8'h90, 127, 127, 1, 12544, 0);
        add(8'h30, 127, 127, 1, 12544, 0);
        add(8'h90, 127, 127, 1, 12544, 0);
        add(8'h45, 127, 127, 1, 12544, 0);
        add(8'h64, 69, 100, 1, 440, 1);

        repeat (3) @(posedge clk);
        #1;
        check("reset_values", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].b);
            check($sformatf("vec%0d_byte%02h", i, tbl[i].b), tbl[i].n, tbl[i].v, tbl[i].g, tbl[i].f, tbl[i].s);
        end

        // Idle cycle after a strobe: pulse is one cycle, outputs hold
        @(posedge clk);
        #1;
        check("strobe_one_cycle", 69, 100, 1, 440, 0);

        // Asynchronous reset mid-message
        send(8'h90);
        send(8'h45);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        send(8'h64);
        check("post_reset_data_dropped", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("post_reset_idle", 0, 0, 0, 0, 0);

        // Fresh message after reset decodes normally
        send(8'h90);
        send(8'h3C);
        send(8'h50);
        check("post_reset_note_on", 60, 80, 1, 261, 1);
        @(posedge clk);
        #1;
        check("post_reset_strobe_clear", 60, 80, 1, 261, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/midi_note_decoder.md
# midi_note_decoder

Parses the raw MIDI byte stream from the UART receiver into a monophonic note state: current note number, velocity, gate and the note's frequency in integer Hz. `freq_out` drives the phase accumulator's `freq_in` directly; `gate` and `velocity` feed the envelope stage. Last-note priority; Note Off only releases the note currently sounding.

## Interface

- `MIDI_CHANNEL`, default 0: channel to respond to (0–15, the low nibble of the status byte).
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `rx_data`  input  8  received MIDI byte.
- `rx_valid`  input  1  one-cycle strobe; `rx_data` is valid this cycle. There is no backpressure; a byte is accepted every cycle `rx_valid` is high.
- `note`  output  7  current MIDI note number.
- `velocity`  output  7  velocity of the current note.
- `gate`  output  1  high while the note is held.
- `freq_out`  output  32  frequency of `note` in Hz, zero-extended integer.
- `note_strobe`  output  1  one-cycle pulse whenever `note`, `velocity` or `gate` changes.

## Operation

- Byte classes:
  - Status: bit 7 set.
  - Data: bit 7 clear.
  - Real-time: 0xF8–0xFF.
- States: IDLE, WAIT_D1, WAIT_D2. Internal `status` register holds 0x00 when no status is stored.
- Real-time bytes in any state are ignored. They change nothing, including state and `status`.
- 0xF0–0xF7 in any state sets `status` to 0x00 and goes to IDLE.
- Channel status 0x80–0xEF in any state, including mid-message:
  - Latch into `status` and go to WAIT_D1.
  - Any partial message is discarded.
- Data byte handling:
  - IDLE: discarded, unless running status applies (see Configuration).
  - WAIT_D1: latch as `d1`. Go to WAIT_D2 for types 8x, 9x, Ax, Bx, Ex. Types Cx and Dx complete here.
  - WAIT_D2: the message completes.
- Messages are acted on only if they are type 8x or 9x and `status[3:0] == MIDI_CHANNEL`. All other messages are consumed silently.
- Note On (9x) with `d2 != 0`:
  - `note <= d1`, `velocity <= d2`, `gate <= 1`, `freq_out <= f(d1)`.
  - `note_strobe` pulses, including on a retrigger of the same note.
- Note Off (8x), or 9x with `d2 == 0`:
  - If `gate == 1` and `d1 == note`: `gate <= 0` and `note_strobe` pulses. `note`, `velocity` and `freq_out` hold.
  - Otherwise: no effect and no strobe.
- Frequency function, with `n = 12k + s`, `k = n/12` (0..10), `s = n%12`: `f(n) = T[s] >> (10 - k)`.
- `T[0..11]` = 8372, 8870, 9397, 9956, 10548, 11175, 11840, 12544, 13290, 14080, 14917, 15804 (C9..B9, rounded).
- Examples: `f(69) = 440`, `f(60) = 261`, `f(0) = 8`, `f(127) = 12544`.

## Timing

- Reset values: `note` = 0, `velocity` = 0, `gate` = 0, `freq_out` = 0, `note_strobe` = 0, state = IDLE, `status` = 0x00.
- Reset is asynchronous and may occur mid-message. The partial message is lost and decoding restarts in IDLE.
- Latency: all outputs update on the clock edge that samples the completing byte with `rx_valid` high. `note_strobe` is high for exactly the following cycle.
- `note`, `velocity`, `gate` and `freq_out` change together on the same edge and are never torn.
- Back-to-back bytes (`rx_valid` high on consecutive cycles) are fully supported.
- `note_strobe` never stays high for two consecutive cycles unless two messages complete on consecutive cycles.

## Configuration

- `MIDI_RUNNING_STATUS_EN`:
  - Defined: after a completed channel message, the state returns to WAIT_D1 with `status` retained. A data byte in IDLE with `status != 0` is treated as `d1`, so repeated messages may omit the status byte.
  - Undefined: after any completed message, `status` is cleared and the state is IDLE. Data bytes without a preceding status are discarded.

## Test plan

- Reset release, then 0x90 0x45 0x64 → `note` = 69, `velocity` = 100, `gate` = 1, `freq_out` = 440; one `note_strobe` on the cycle after the 0x64 edge.
- Hold A4, send 0x90 0x3C 0x50 then 0x80 0x45 0x00 → note 60 sounds at `freq_out` = 261; the Note Off for 69 is ignored (`gate` stays 1, no strobe). Then 0x90 0x3C 0x00 → `gate` = 0, `freq_out` stays 261.
- Send 0x91 0x45 0x64 with `MIDI_CHANNEL` = 0, then 0xC0 0x05 → no output change and no strobe; the next 0x90 0x30 0x7F decodes correctly (`freq_out` = 130).
- 0x90 0x40, then 0xF8, then 0x7F → 0xF8 is ignored and the note-on for note 64 completes (`freq_out` = 329).
- 0x90 0x45 0x64 0x48 0x64:
  - With `MIDI_RUNNING_STATUS_EN`: second note 72, `freq_out` = 523.
  - Without it: trailing bytes are discarded and `note` stays 69.
- Assert `reset` after 0x90 0x45, then send 0x64 → outputs stay at reset values; the byte is discarded.
